// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: launches a counted, timed pulse train on a rising edge of start.
// Ports: clk, rst (sync, active-low); start (edge-launched), abort (level);
//   period/width/num_pulses (config, latched on the start edge);
//   pulse_out, busy, done (strobe), err (strobe), pulse_idx (current pulse, 0-based).
// Optional: define PTC_CONTINUOUS_EN to make num_pulses==0 an endless train.
module pulse_train_ctrl #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NUM_W-1:0] pulse_idx
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, wid_q, wid_d;
  logic [NUM_W-1:0] num_q, num_d, idx_q, idx_d;
  logic start_q, err_q, err_d, pulse_q, busy_q, done_q;
  logic start_edge, bad_cfg, last;
  always_comb begin
    start_edge = start & ~start_q;
`ifdef PTC_CONTINUOUS_EN
    bad_cfg = (period == '0) | (width == '0) | (width >= period);
    last    = (num_q != '0) & (idx_q == num_q - NUM_W'(1));
`else
    bad_cfg = (period == '0) | (width == '0) | (width >= period) | (num_pulses == '0);
    last    = idx_q == num_q - NUM_W'(1);
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    per_d   = per_q;
    wid_d   = wid_q;
    num_d   = num_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        err_d = bad_cfg;
        if (!bad_cfg) begin
          state_d = HIGH;
          cnt_d   = '0;
          idx_d   = '0;
          per_d   = period;
          wid_d   = width;
          num_d   = num_pulses;
        end
      end
      // cnt runs across the whole period; HIGH ends at width-1, LOW at period-1
      HIGH: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = abort ? IDLE : (cnt_q == wid_q - CNT_W'(1)) ? LOW : HIGH;
      end
      LOW: begin
        cnt_d = (cnt_q == per_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
        if (abort) state_d = IDLE;
        else if (cnt_q == per_q - CNT_W'(1)) begin
          state_d = last ? DONE : HIGH;
          idx_d   = last ? idx_q : idx_q + NUM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      per_q   <= '0;
      wid_q   <= '0;
      num_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      num_q   <= num_d;
      start_q <= start;
      err_q   <= err_d;
      pulse_q <= state_d == HIGH;
      busy_q  <= (state_d == HIGH) | (state_d == LOW);
      done_q  <= state_d == DONE;
    end
  end
  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pulse_idx = idx_q;
endmodule

// File: tb/tb_pulse_train_ctrl.sv
// tb_pulse_train_ctrl: directed bench comparing pulse_train_ctrl against an arithmetic train model.
module tb_pulse_train_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] period = '0, width = '0;
  logic [7:0] num_pulses = '0;
  logic pulse_out, busy, done, err;
  logic [7:0] pulse_idx;
  int n_cmp = 0, n_bad = 0;
  pulse_train_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .period(period), .width(width),
    .num_pulses(num_pulses), .pulse_out(pulse_out), .busy(busy), .done(done), .err(err),
    .pulse_idx(pulse_idx)
  );
  always #5 clk = ~clk;
  bit m_sp = 0, m_act = 0, m_inf = 0, se;
  int m_k = 0, m_per = 1, m_wid = 0, m_tot = 0, m_idx = 0;
  bit e_p = 0, e_b = 0, e_d = 0, e_e = 0;
  function automatic bit illegal(int p, int w, int n);
`ifdef PTC_CONTINUOUS_EN
    return p == 0 || w == 0 || w >= p;
`else
    return p == 0 || w == 0 || w >= p || n == 0;
`endif
  endfunction
  // Expected outputs for the cycle after each edge: a train started at edge E
  // is at offset k = cycle-(E+1); pulse k/period is high while k%period < width.
  always @(posedge clk) begin
    if (!rst) begin
      m_sp = 0; m_act = 0; m_idx = 0; e_p = 0; e_b = 0; e_d = 0; e_e = 0;
    end else begin
      se = start && !m_sp;
      m_sp = start;
      e_e = 0;
      if (m_act) begin
        if (m_inf || m_k < m_tot) begin
          if (abort) m_act = 0;
          else m_k++;
        end else m_act = 0;
      end else if (se) begin
        if (illegal(int'(period), int'(width), int'(num_pulses))) e_e = 1;
        else begin
          m_act = 1; m_k = 0; m_per = int'(period); m_wid = int'(width);
          m_inf = num_pulses == 0; m_tot = int'(num_pulses) * m_per;
        end
      end
      e_p = 0; e_b = 0; e_d = 0;
      if (m_act && (m_inf || m_k < m_tot)) begin
        e_p = (m_k % m_per) < m_wid; e_b = 1; m_idx = (m_k / m_per) % 256;
      end else if (m_act) e_d = 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("pulse_out", 32'(pulse_out), 32'(e_p));
    chk("busy", 32'(busy), 32'(e_b));
    chk("done", 32'(done), 32'(e_d));
    chk("err", 32'(err), 32'(e_e));
    chk("pulse_idx", 32'(pulse_idx), 32'(m_idx));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic cfg(input int p, input int w, input int n);
    period = 16'(p); width = 16'(w); num_pulses = 8'(n);
  endtask
  initial begin
    int nb, nd;
    @(posedge clk);
    run(3);
    rst = 1'b1;
    run(10);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_pulse", 32'(pulse_out), 0);
    cfg(4, 1, 3); start = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      cyc();
      if (j == 1 || j == 5 || j == 9) chk("basic_pulse_hi", 32'(pulse_out), 1);
      if (j == 2 || j == 4) chk("basic_pulse_lo", 32'(pulse_out), 0);
      if (j == 5) chk("basic_idx1", 32'(pulse_idx), 1);
      if (j == 9) chk("basic_idx2", 32'(pulse_idx), 2);
      if (j == 12) chk("basic_busy_last", 32'(busy), 1);
      if (j == 13) chk("basic_done", 32'(done), 1);
      if (j == 13) chk("basic_done_busy", 32'(busy), 0);
      if (j == 3) start = 1'b0;
    end
    cfg(3, 2, 2); start = 1'b1; nb = 0; nd = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      nb += int'(busy); nd += int'(done);
      if (j == 2) start = 1'b0;
      if (j == 3) start = 1'b1;
    end
    chk("held_busy_cycles", 32'(nb), 6);
    chk("held_done_count", 32'(nd), 1);
    start = 1'b0; run(2);
    cfg(5, 5, 1); start = 1'b1;
    cyc();
    chk("illegal_err", 32'(err), 1);
    chk("illegal_busy", 32'(busy), 0);
    cyc();
    chk("illegal_err_clear", 32'(err), 0);
    start = 1'b0; run(2);
    cfg(0, 1, 1); start = 1'b1;
    cyc();
    chk("per0_err", 32'(err), 1);
    chk("per0_pulse", 32'(pulse_out), 0);
    start = 1'b0; run(3);
    cfg(8, 4, 5); start = 1'b1;
    run(10);
    start = 1'b0; abort = 1'b1;
    cyc();
    chk("abort_pulse", 32'(pulse_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_idx", 32'(pulse_idx), 1);
    abort = 1'b0; nd = 0;
    for (int j = 0; j < 40; j++) begin cyc(); nd += int'(done); end
    chk("abort_no_done", 32'(nd), 0);
    cfg(2, 1, 1); start = 1'b1; abort = 1'b1;
    cyc();
    chk("start_beats_abort", 32'(busy), 1);
    abort = 1'b0; start = 1'b0;
    run(2);
    chk("short_done", 32'(done), 1);
    run(2);
    cfg(4, 2, 3); start = 1'b1;
    run(5);
    rst = 1'b0; start = 1'b0;
    cyc();
    chk("rst_kills_busy", 32'(busy), 0);
    chk("rst_idx", 32'(pulse_idx), 0);
    rst = 1'b1; nd = 0;
    for (int j = 0; j < 20; j++) begin cyc(); nd += int'(done); end
    chk("rst_no_done", 32'(nd), 0);
    cfg(2, 1, 0); start = 1'b1;
`ifdef PTC_CONTINUOUS_EN
    nd = 0;
    for (int j = 1; j <= 600; j++) begin
      cyc();
      nd += int'(done);
      if (j == 2) start = 1'b0;
      if (j == 511) chk("cont_idx255", 32'(pulse_idx), 255);
      if (j == 513) chk("cont_idx_wrap", 32'(pulse_idx), 0);
    end
    chk("cont_busy", 32'(busy), 1);
    abort = 1'b1;
    cyc();
    chk("cont_abort_busy", 32'(busy), 0);
    abort = 1'b0;
    run(5);
    chk("cont_no_done", 32'(nd), 0);
`else
    cyc();
    chk("num0_err", 32'(err), 1);
    chk("num0_busy", 32'(busy), 0);
    start = 1'b0;
    run(5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_train_ctrl.md
Name: pulse_train_ctrl

Overview:
- Controller that sequences programmable pulse trains.
- A rising edge on `start` latches a configuration (period, high width, pulse count). The block then drives `pulse_out` for the requested number of pulses.
- Sits above the single-cycle pulse generator level. It turns an edge event into a timed, counted burst and reports busy/done/error status to the host logic.

Parameters:
- CNT_W, 16, width of the period and width configuration fields and of the internal phase counter.
- NUM_W, 8, width of the pulse-count field and of `pulse_idx`.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- start  input  1  level input; only its 0->1 transition, detected internally, launches a train.
- abort  input  1  level; terminates an active train.
- period  input  CNT_W  cycles per pulse (high + low); sampled on the start edge.
- width  input  CNT_W  high cycles per pulse; sampled on the start edge.
- num_pulses  input  NUM_W  pulses in the train; sampled on the start edge.
- pulse_out  output  1  registered pulse train output.
- busy  output  1  train in progress.
- done  output  1  one-cycle strobe when a train completes normally.
- err  output  1  one-cycle strobe when a start edge carries an illegal configuration.
- pulse_idx  output  NUM_W  0-based index of the current pulse; holds the last index after completion.

Behaviour:
- Reset (rst=0 at a clk edge):
  - pulse_out=0, busy=0, done=0, err=0, pulse_idx=0.
  - Internal start-delay register=0, FSM=IDLE.
  - Reset mid-train kills the train immediately and does not assert done.
- Edge detect:
  - `start_edge` = start & ~start_q; start_q is registered every cycle, including while busy.
  - A start held high does not retrigger. Start edges while busy are ignored and not queued.
- Config check on start_edge in IDLE:
  - Illegal if period==0, width==0, width>=period, or num_pulses==0 (see optional feature for the last case).
  - Illegal config: err=1 for the following cycle; FSM stays IDLE; no other output changes.
- FSM states: IDLE, HIGH, LOW, DONE.
  - IDLE -> HIGH on a legal start_edge (edge sampled at clk edge E).
    - Config is latched, phase counter=0, pulse_idx=0.
    - pulse_out=1 and busy=1 from cycle E+1.
  - HIGH lasts exactly `width` cycles, then -> LOW with pulse_out=0.
  - LOW lasts exactly period-width cycles. At the end of LOW:
    - If pulse_idx==num_pulses-1: -> DONE.
    - Otherwise: pulse_idx+1 -> HIGH.
  - DONE lasts 1 cycle: done=1, busy=0, pulse_out=0. Then -> IDLE.
- Timing totals:
  - busy is high for exactly num_pulses*period cycles.
  - done appears in the cycle E+num_pulses*period+1.
- Abort:
  - abort=1 sampled in HIGH or LOW: next cycle FSM=IDLE, pulse_out=0, busy=0, done=0, pulse_idx holds.
  - Abort has priority over end-of-train in the same cycle.
  - Abort in IDLE or DONE has no effect. In DONE, done still strobes.
- Simultaneous abort and start_edge in IDLE: start wins, because abort only acts while busy.
- Config inputs may change freely while busy; only the values latched at the start edge are used.
- Counters are CNT_W-bit. Maximum period is 2^CNT_W-1 with no wrap-around hazard.

Optional Feature:
- Macro: PTC_CONTINUOUS_EN.
- Defined:
  - num_pulses==0 is legal and means an endless train, terminated only by abort or reset.
  - pulse_idx wraps modulo 2^NUM_W.
  - done is never asserted for an endless train.
- Undefined: num_pulses==0 is illegal and yields an err strobe.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with start=0 -> all outputs 0 for 10 cycles.
- Basic train: period=4, width=1, num_pulses=3, start 0->1 sampled at edge E:
  - pulse_out=1 only in cycles E+1, E+5 and E+9.
  - busy=1 for cycles E+1..E+12.
  - done=1 only at E+13.
  - pulse_idx steps 0,1,2.
- Held/retrigger: keep start=1 through the whole period=3, width=2, num_pulses=2 train -> exactly one train (6 busy cycles). Toggling start 0->1 mid-train has no effect.
- Illegal config: period=5, width=5, start edge -> err=1 for one cycle; pulse_out and busy stay 0.
  - Repeat with period=0 -> same result.
- Abort: period=8, width=4, num_pulses=5, abort=1 asserted in the second HIGH phase -> next cycle pulse_out=0 and busy=0, done never asserts, pulse_idx=1.
- Continuous (PTC_CONTINUOUS_EN defined): num_pulses=0, period=2, width=1:
  - Pulses continue for 600 cycles and pulse_idx wraps 255->0.
  - abort stops the train with no done.
  - With the macro undefined, the same stimulus gives an err strobe only.
